// File: rtl/ctr_game_pkg.sv
// Shared types for the counter-game driver: FSM states, control codes, defaults.
package ctr_game_pkg;

    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, STALL, DONE} state_t;

    typedef enum logic [1:0] {CTRL_00 = 2'b00, CTRL_01 = 2'b01,
                              CTRL_10 = 2'b10, CTRL_11 = 2'b11} ctrl_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_move_fifo.sv
// Move queue feeding the driver; flush wins over push/pop, full+pop+push is legal.
module game_move_fifo
    import ctr_game_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int W     = 2
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    input  logic         flush,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/game_driver.sv
// Plays queued control codes into the counter game: preload, timed moves, stall, capture result.
module game_driver
    import ctr_game_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int INIT_CYCLES = 2
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] seed_value,
    input  logic [7:0] dwell,
    input  logic       move_wr,
    input  logic [1:0] move_data,
    input  logic       gameover,
    input  logic [1:0] who,
    output logic [1:0] control,
    output logic [3:0] initial_value,
    output logic       INIT,
    output logic       move_full,
    output logic       overflow,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [7:0] moves_played
);
    localparam int LCW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_t         state, nstate;
    logic [LCW-1:0] load_cnt;
    logic [7:0]     hold_cnt;
    logic [1:0]     head;
    logic           fifo_full, fifo_empty;
    logic           pop, flush, start_ok, hold_done, drop;

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign hold_done = (hold_cnt < 8'd2);
    assign move_full = fifo_full;
    assign drop      = move_wr && fifo_full && !pop && !flush;

    game_move_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (move_wr),
        .wdata (move_data),
        .pop   (pop),
        .rdata (head),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE, DONE: if (start) nstate = LOAD;
            LOAD:       if (load_cnt == LCW'(INIT_CYCLES - 1)) nstate = PLAY;
            PLAY: begin
                if (gameover)                     nstate = DONE;
                else if (hold_done && fifo_empty) nstate = STALL;
            end
            STALL: begin
                if (gameover)         nstate = DONE;
                else if (!fifo_empty) nstate = PLAY;
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        INIT  = (state == LOAD);
        busy  = (state == LOAD) || (state == PLAY) || (state == STALL);
        done  = (state == DONE);
        flush = ((state == PLAY) || (state == STALL)) && gameover;
        // gameover outranks a pop due in the same cycle
        pop   = (state == PLAY) && !gameover && hold_done && !fifo_empty;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            control       <= CTRL_00;
            initial_value <= '0;
            result        <= '0;
            moves_played  <= '0;
            overflow      <= 1'b0;
            load_cnt      <= '0;
            hold_cnt      <= '0;
        end else begin
            if (start_ok) begin
                initial_value <= seed_value;
                result        <= '0;
                moves_played  <= '0;
                overflow      <= 1'b0;
                load_cnt      <= '0;
            end else begin
                if (state == LOAD) load_cnt <= load_cnt + LCW'(1);
                if (drop)          overflow <= 1'b1;
            end
            if (flush) result <= who;
            if (pop) begin
                control      <= head;
                moves_played <= sat_inc8(moves_played);
                hold_cnt     <= (dwell == 8'd0) ? 8'd1 : dwell;
            end else if (state != PLAY) begin
                hold_cnt <= '0;
            end else if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_game_driver.sv
// Directed scenarios plus random traffic against a queue-based game model.
module tb_game_driver;
    localparam int DEPTH = 8;
    localparam int ICYC  = 2;

    logic       clock = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, move_wr = 1'b0, gameover = 1'b0;
    logic [3:0] seed_value = '0;
    logic [7:0] dwell = '0;
    logic [1:0] move_data = '0, who = '0;
    logic [1:0] control, result;
    logic [3:0] initial_value;
    logic       INIT, move_full, overflow, busy, done;
    logic [7:0] moves_played;

    int n_chk = 0, n_err = 0;
    int exp_ctl[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 2};

    game_driver #(.FIFO_DEPTH(DEPTH), .INIT_CYCLES(ICYC)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .seed_value(seed_value),
        .dwell(dwell), .move_wr(move_wr), .move_data(move_data),
        .gameover(gameover), .who(who), .control(control),
        .initial_value(initial_value), .INIT(INIT), .move_full(move_full),
        .overflow(overflow), .busy(busy), .done(done), .result(result),
        .moves_played(moves_played)
    );

    always #5 clock = ~clock;

    // Model: queue of moves, cycles left in the preload, cycles left on the current move.
    logic [1:0] q[$];
    int m_load, m_hold, m_ctrl, m_iv, m_res, m_mp;
    bit m_play, m_stall, m_done, m_ovf;

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_load = 0; m_hold = 0; m_ctrl = 0; m_iv = 0; m_res = 0; m_mp = 0;
        m_play = 0; m_stall = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit full_pre, popd, flushd, st_ok;
        full_pre = (q.size() == DEPTH);
        st_ok    = start && !((m_load > 0) || m_play);
        popd     = 0;
        flushd   = 0;
        if (st_ok) begin
            m_load = ICYC; m_done = 0; m_iv = int'(seed_value);
            m_res = 0; m_mp = 0; m_ovf = 0;
        end else if (m_load > 0) begin
            m_load--;
            if (m_load == 0) begin m_play = 1; m_stall = 0; m_hold = 0; end
        end else if (m_play) begin
            if (gameover) begin
                m_play = 0; m_done = 1; m_res = int'(who); flushd = 1;
            end else if (m_stall) begin
                if (q.size() > 0) m_stall = 0;
            end else if (m_hold > 1) begin
                m_hold--;
            end else if (q.size() > 0) begin
                m_ctrl = int'(q.pop_front());
                popd   = 1;
                m_hold = (dwell == 0) ? 1 : int'(dwell);
                if (m_mp < 255) m_mp++;
            end else begin
                m_stall = 1; m_hold = 0;
            end
        end
        if (flushd) q.delete();
        else if (move_wr) begin
            if (!full_pre || popd) q.push_back(move_data);
            else if (!st_ok)       m_ovf = 1;
        end
    endtask

    task automatic check_all();
        chk("control", int'(control), m_ctrl);
        chk("initial_value", int'(initial_value), m_iv);
        chk("INIT", int'(INIT), int'(m_load > 0));
        chk("move_full", int'(move_full), int'(q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'((m_load > 0) || m_play));
        chk("done", int'(done), int'(m_done));
        chk("result", int'(result), m_res);
        chk("moves_played", int'(moves_played), m_mp);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        check_all();
        rst_n = 1'b1;

        // preload with seed 9, then moves 01/10 held 3 cycles each
        move_wr = 1'b1; move_data = 2'd1; tick();
        move_data = 2'd2; tick();
        move_wr = 1'b0; start = 1'b1; seed_value = 4'd9; dwell = 8'd3; tick();
        start = 1'b0;
        chk("preload_iv", int'(initial_value), 9);
        chk("preload_init", int'(INIT), 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold_ctl", int'(control), exp_ctl[i]);
            chk("load_init", int'(INIT), (i == 0) ? 1 : 0);
        end
        chk("hold_mp", int'(moves_played), 2);

        // stall holds control, a push resumes play the cycle after
        move_wr = 1'b1; move_data = 2'd3; tick();
        move_wr = 1'b0;
        chk("stall_ctl", int'(control), 2);
        tick();
        chk("stall_ctl2", int'(control), 2);
        tick();
        chk("resume_ctl", int'(control), 3);

        // gameover with moves pending
        move_wr = 1'b1; move_data = 2'd1; tick();
        move_data = 2'd0; tick();
        move_wr = 1'b0; gameover = 1'b1; who = 2'd2; tick();
        gameover = 1'b0;
        chk("end_done", int'(done), 1);
        chk("end_result", int'(result), 2);
        chk("end_mp", int'(moves_played), 3);
        start = 1'b1; tick();
        start = 1'b0;
        repeat (4) tick();
        chk("flushed_mp", int'(moves_played), 0);

        // overflow: 9 pushes with no pops
        gameover = 1'b1; who = 2'd1; tick();
        gameover = 1'b0;
        move_wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            move_data = 2'($urandom); tick();
        end
        move_wr = 1'b0;
        chk("ovf_full", int'(move_full), 1);
        chk("ovf_flag", int'(overflow), 1);
        start = 1'b1; dwell = 8'd2; tick();
        start = 1'b0;
        chk("ovf_clear", int'(overflow), 0);
        repeat (5) tick();

        // asynchronous reset mid-game
        #2 rst_n = 1'b0;
        #1;
        chk("rst_control", int'(control), 0);
        chk("rst_iv", int'(initial_value), 0);
        chk("rst_init", int'(INIT), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mp", int'(moves_played), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_full", int'(move_full), 0);
        model_reset();
        @(negedge clock);
        check_all();
        rst_n = 1'b1;

        // long game with one-cycle moves: moves_played saturates
        start = 1'b1; seed_value = 4'd5; tick();
        start = 1'b0; move_wr = 1'b1; dwell = 8'd0;
        repeat (270) begin
            move_data = 2'($urandom); tick();
        end
        chk("mp_sat", int'(moves_played), 255);
        move_wr = 1'b0; gameover = 1'b1; who = 2'd3; tick();
        gameover = 1'b0;

        repeat (3000) begin
            start      = ($urandom_range(0, 39) == 0);
            seed_value = 4'($urandom);
            dwell      = 8'($urandom_range(0, 4));
            move_wr    = ($urandom_range(0, 1) == 0);
            move_data  = 2'($urandom);
            gameover   = ($urandom_range(0, 59) == 0);
            who        = 2'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/game_driver.md
GAME_DRIVER -- requirements
Module: game_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, using the port names clock and rst_n.
REQ-002 The block SHALL have these parameters, one per line:
- FIFO_DEPTH, 8, move FIFO entries (power of 2).
- INIT_CYCLES, 2, cycles INIT is held high per game.
REQ-003 The block SHALL have these ports, one per line:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle game-start request.
- seed_value  in  4  counter preload value, captured on accepted start.
- dwell  in  8  cycles each move is held; 0 is treated as 1.
- move_wr  in  1  push move_data into the move FIFO.
- move_data  in  2  control code to play.
- gameover  in  1  counter end-of-game flag.
- who  in  2  counter winner code, valid with gameover.
- control  out  2  control code to the counter.
- initial_value  out  4  preload value to the counter.
- INIT  out  1  counter load strobe.
- move_full  out  1  move FIFO full.
- overflow  out  1  sticky flag: a push was dropped.
- busy  out  1  state is LOAD, PLAY or STALL.
- done  out  1  state is DONE.
- result  out  2  captured who value.
- moves_played  out  8  moves popped this game.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, LOAD, PLAY, STALL and DONE.
REQ-005 start SHALL be accepted only in IDLE or DONE, and ignored elsewhere.
REQ-006 An accepted start SHALL move the FSM to LOAD and capture seed_value into initial_value.
REQ-007 An accepted start SHALL clear result, moves_played and overflow.
REQ-008 LOAD SHALL drive INIT=1 for exactly INIT_CYCLES cycles, then enter PLAY with INIT=0.
REQ-009 gameover SHALL be ignored while in LOAD.
REQ-010 In PLAY with the FIFO non-empty, the FSM SHALL pop the head move and drive control with it starting the next cycle.
REQ-011 Each popped move SHALL be held for max(dwell,1) cycles, with dwell sampled at pop time.
REQ-012 moves_played SHALL increment once per pop and saturate at 255.
REQ-013 If the FIFO is empty when a hold expires, the FSM SHALL enter STALL.
REQ-014 In STALL, control SHALL keep its last value.
REQ-015 STALL SHALL return to PLAY the cycle after the FIFO becomes non-empty.
REQ-016 gameover=1 in PLAY or STALL SHALL, on the next edge, enter DONE, capture who into result and flush the FIFO.
REQ-017 gameover SHALL take priority over any pop in the same cycle.
REQ-018 In DONE, control SHALL hold its value, INIT SHALL be 0, and done SHALL be 1 until an accepted start.
REQ-019 move_wr with the FIFO full SHALL be dropped and SHALL set overflow.
REQ-020 A simultaneous push and pop with the FIFO full SHALL both succeed.
REQ-021 move_full SHALL be asserted combinationally when the occupancy equals FIFO_DEPTH.
REQ-022 Pushes SHALL be accepted in every state except during the DONE-entry flush cycle.

Reset
REQ-023 rst_n=0 SHALL force, asynchronously, state IDLE, control=00, initial_value=0, INIT=0, result=0, moves_played=0, overflow=0, and an empty FIFO.
REQ-024 A reset asserted mid-game SHALL abandon the game with no further counter strobes.

Structure
REQ-025 Package ctr_game_pkg SHALL hold the FSM state enum, the control-code constants (00, 01, 10, 11) and the FIFO_DEPTH default.
REQ-026 The move FIFO SHALL be the sub-module game_move_fifo, with push, pop, full, empty and flush ports.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Preload: start with seed 9, INIT_CYCLES=2 -> INIT=1 for 2 cycles, initial_value=9, then PLAY.
- Move hold: push moves 01 and 10, dwell=3 -> control=01 for 3 cycles, then 10 for 3 cycles, moves_played=2.
- Stall: empty FIFO after 1 move -> STALL, control held; a later push -> PLAY the cycle after.
- Game end: gameover=1 with who=2 while moves are pending -> DONE next edge, result=2, FIFO empty, done=1.
- Overflow: 9 pushes with no pop -> 8 stored, move_full=1, overflow=1; the next start clears overflow.
- Mid-game reset: rst_n low during PLAY -> all outputs reach reset values immediately, without waiting for a clock edge.
